puf_soc_frame_packer: RTL and testbench

//  Parametrised frame builder for the PUF SoC readout path; replaces the fixed 2-channel assembler.

---
 rtl/puf_soc_pkg.sv | 27 ++
 rtl/puf_frame_fifo.sv | 43 ++++
 rtl/puf_soc_frame_packer.sv | 98 +++++++++
 tb/tb_puf_soc_frame_packer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/puf_soc_pkg.sv
// puf_soc_pkg: shared constants and helpers for the PUF SoC frame packer
// Provides the sync byte, header field offsets, payload width calculation and the frame checksum.
package puf_soc_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int SYNC_LSB  = 0;
    localparam int HDR_LSB   = 8;
    localparam int PAY_LSB   = 16;
    localparam int SEQ_W     = 6;
    localparam int FRAME_MAX = 1024;

    // Debug payload is the widest layout, so it sets the payload register width.
    function automatic int payload_w(input int cnt_w, input int nch, input int mux);
        return nch * $clog2(mux) + 3 + mux + nch + (nch + 1) * cnt_w;
    endfunction

    localparam int PAYLOAD_W = payload_w(32, 2, 16);

    function automatic logic [7:0] frame_xor(input logic [FRAME_MAX-1:0] v, input int nbytes);
        logic [7:0] x;
        x = '0;
        for (int b = 0; b < FRAME_MAX / 8; b++)
            if (b < nbytes) x = x ^ v[b*8 +: 8];
        return x;
    endfunction

endpackage

// File: rtl/puf_frame_fifo.sv
// puf_frame_fifo: shift-register sync FIFO whose head entry drives dout straight from a flop
// Ports: push/din write side, ready pops the head when valid, level is occupancy,
// wr_ok flags a push that was accepted (room available or a pop in the same cycle).
module puf_frame_fifo #(
    parameter int WIDTH = 160,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     wr_ok
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop;
    logic [AW:0]      wr_idx;

    assign valid  = level != '0;
    assign pop    = valid & ready;
    assign wr_ok  = push & (level != (AW + 1)'(DEPTH) | pop);
    assign wr_idx = level - (AW + 1)'(pop);
    assign dout   = mem[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            level <= '0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (pop) mem[i] <= mem[i+1];
            if (wr_ok) mem[wr_idx[AW-1:0]] <= din;
            level <= level + (AW + 1)'(wr_ok) - (AW + 1)'(pop);
        end
    end

endmodule

// File: rtl/puf_soc_frame_packer.sv
// puf_soc_frame_packer: builds sync/header/payload/checksum frames from counter snapshots and queues them
// Ports: i_assmblr_en captures one frame, i_op_mode picks debug or normal payload, i_clr_stats clears
// seq/drop/loss; o_frame_data/o_frame_valid/i_frame_ready form the output handshake; o_drop_cnt counts
// frames lost on a full FIFO; o_fifo_level is occupancy.
module puf_soc_frame_packer
    import puf_soc_pkg::*;
#(
    parameter int CNT_BIT_SIZE = 32,
    parameter int NUM_CH       = 2,
    parameter int MUX_LENGTH   = 16,
    parameter int FRAM_SIZE    = 160,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_op_mode,
    input  logic                                  i_assmblr_en,
    input  logic                                  i_clr_stats,
    input  logic [CNT_BIT_SIZE-1:0]               i_cnt_lser,
    input  logic [NUM_CH*CNT_BIT_SIZE-1:0]        i_cnt_ch,
    input  logic [NUM_CH-1:0]                     i_full_ch,
    input  logic [MUX_LENGTH-1:0]                 i_ro_bnk_en,
    input  logic [2:0]                            i_fsm_state,
    input  logic [NUM_CH*$clog2(MUX_LENGTH)-1:0]  i_sel_mux,
    output logic [FRAM_SIZE-1:0]                  o_frame_data,
    output logic                                  o_frame_valid,
    input  logic                                  i_frame_ready,
    output logic [15:0]                           o_drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]           o_fifo_level
);

    localparam int PW = payload_w(CNT_BIT_SIZE, NUM_CH, MUX_LENGTH);

    if (FRAM_SIZE % 8 != 0 || FRAM_SIZE < 24 + PW || FRAM_SIZE > FRAME_MAX) begin : g_bad_frame
        $error("puf_soc_frame_packer: FRAM_SIZE must be a multiple of 8 and hold header, payload and checksum");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("puf_soc_frame_packer: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic                 s1_v, s1_dbg, s2_v, s2_dbg, loss, wr_ok, drop;
    logic [PW-1:0]        s1_pay;
    logic [FRAM_SIZE-1:0] body, s2_body, frame;
    logic [7:0]           s2_par, hdr;
    logic [SEQ_W-1:0]     seq;
    logic [15:0]          drop_cnt;

    // Seq and loss are only known at the push itself (drops must not consume a seq), so S2 carries
    // the checksum of everything except the header byte and the header is folded in at the push.
    assign body  = (FRAM_SIZE'(SYNC_BYTE) << SYNC_LSB) | (FRAM_SIZE'(s1_pay) << PAY_LSB);
    assign hdr   = {loss, s2_dbg, seq};
    assign frame = s2_body | (FRAM_SIZE'(hdr) << HDR_LSB) | (FRAM_SIZE'(s2_par ^ hdr) << (FRAM_SIZE - 8));
    assign drop  = s2_v & ~wr_ok;
    assign o_drop_cnt = drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_dbg   <= 1'b0;
            s1_pay   <= '0;
            s2_v     <= 1'b0;
            s2_dbg   <= 1'b0;
            s2_body  <= '0;
            s2_par   <= '0;
            seq      <= '0;
            loss     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            s1_v     <= i_assmblr_en;
            s1_dbg   <= i_op_mode;
            s1_pay   <= i_op_mode ? {i_sel_mux, i_fsm_state, i_ro_bnk_en, i_full_ch, i_cnt_ch, i_cnt_lser}
                                  : PW'({i_full_ch, i_cnt_lser});
            s2_v     <= s1_v;
            s2_dbg   <= s1_dbg;
            s2_body  <= body;
            s2_par   <= frame_xor(FRAME_MAX'(body), FRAM_SIZE / 8 - 1);
            seq      <= i_clr_stats ? '0 : seq + SEQ_W'(wr_ok);
            loss     <= ~i_clr_stats & (drop | (loss & ~wr_ok));
            drop_cnt <= i_clr_stats ? '0 : drop_cnt + 16'(drop && drop_cnt != 16'hFFFF);
        end
    end

    puf_frame_fifo #(
        .WIDTH(FRAM_SIZE),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s2_v),
        .din   (frame),
        .ready (i_frame_ready),
        .dout  (o_frame_data),
        .valid (o_frame_valid),
        .level (o_fifo_level),
        .wr_ok (wr_ok)
    );

endmodule

// File: tb/tb_puf_soc_frame_packer.sv
// tb_puf_soc_frame_packer: directed stimulus with a queue-based frame model checked every cycle
module tb_puf_soc_frame_packer;
    import puf_soc_pkg::*;

    localparam int CW = 32, NC = 2, ML = 16, FS = 160, D = 4;

    logic           clk, rst, mode, en, clr, rdy;
    logic [CW-1:0]  lser;
    logic [NC*CW-1:0] ch;
    logic [NC-1:0]  full;
    logic [ML-1:0]  ro;
    logic [2:0]     fsm;
    logic [7:0]     sel;
    logic [FS-1:0]  data;
    logic           valid;
    logic [15:0]    drop;
    logic [2:0]     level;

    int checks = 0, errors = 0;

    puf_soc_frame_packer dut (
        .clk(clk), .rst(rst), .i_op_mode(mode), .i_assmblr_en(en), .i_clr_stats(clr),
        .i_cnt_lser(lser), .i_cnt_ch(ch), .i_full_ch(full), .i_ro_bnk_en(ro),
        .i_fsm_state(fsm), .i_sel_mux(sel), .o_frame_data(data), .o_frame_valid(valid),
        .i_frame_ready(rdy), .o_drop_cnt(drop), .o_fifo_level(level)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    localparam logic [FS-1:0] LIT_N = {8'hAF, 96'h0, 8'h02, 32'h1234_5678, 8'h00, 8'hA5};
    localparam logic [FS-1:0] LIT_D = {8'h89, 11'h0, 8'h3C, 3'd5, 16'h00FF, 2'b00, 64'h0, 32'h0, 8'h40, 8'hA5};

    typedef struct packed {
        logic                 v;
        logic                 dbg;
        logic [PAYLOAD_W-1:0] pay;
    } item_t;

    logic [FS-1:0] exp_q[$];
    int  m_seq, m_drop;
    bit  m_loss;
    item_t st1, st2;

    function automatic logic [FS-1:0] build(input bit dbg, input logic [PAYLOAD_W-1:0] pay,
                                            input int s, input bit l);
        logic [FS-1:0] f;
        logic [7:0] x;
        f = '0;
        f[7:0] = 8'hA5;
        f[15:8] = {l, dbg, 6'(s)};
        f[16 +: PAYLOAD_W] = pay;
        x = '0;
        for (int b = 0; b < FS / 8 - 1; b++) x = x ^ f[b*8 +: 8];
        f[FS-1 -: 8] = x;
        return f;
    endfunction

    task automatic chk(input string nm, input logic [FS-1:0] act, input logic [FS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Model: two capture slots ahead of a queue of frames the FIFO must hold.
    initial forever begin
        logic [FS-1:0] f;
        bit pop, acc;
        @(posedge clk or posedge rst);
        if (rst) begin
            exp_q.delete();
            m_seq = 0; m_drop = 0; m_loss = 0;
            st1 = '0; st2 = '0;
        end else begin
            pop = exp_q.size() > 0 && rdy;
            acc = 0;
            f = '0;
            if (st2.v) begin
                if (exp_q.size() < D || pop) begin
                    f = build(st2.dbg, st2.pay, m_seq, m_loss);
                    acc = 1;
                    m_seq = (m_seq + 1) % 64;
                    m_loss = 0;
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_loss = 1;
                end
            end
            if (clr) begin m_seq = 0; m_drop = 0; m_loss = 0; end
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(f);
            st2 = st1;
            st1.v = en;
            st1.dbg = mode;
            st1.pay = mode ? {sel, fsm, ro, full, ch, lser} : PAYLOAD_W'({full, lser});
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("valid", FS'(valid), FS'(exp_q.size() > 0));
            chk("level", FS'(level), FS'(exp_q.size()));
            chk("drop_cnt", FS'(drop), FS'(m_drop));
            if (exp_q.size() > 0) chk("head", data, exp_q[0]);
        end
    end

    task automatic do_reset();
        rst = 1; en = 0; clr = 0; rdy = 0; mode = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic pop_expect(input logic [7:0] h, input string nm);
        int n = 0;
        while (!valid && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_valid"}, FS'(valid), FS'(1));
        chk({nm, "_hdr"}, FS'(data[15:8]), FS'(h));
        @(negedge clk);
    endtask

    initial begin
        rst = 1; en = 0; clr = 0; rdy = 0; mode = 0;
        lser = '0; ch = '0; full = '0; ro = '0; fsm = '0; sel = '0;
        #1;
        chk("rst_valid", FS'(valid), '0);
        chk("rst_data", data, '0);
        chk("rst_level", FS'(level), '0);
        chk("rst_drop", FS'(drop), '0);
        do_reset();

        // normal frame and latency
        lser = 32'h1234_5678; full = 2'b10; en = 1;
        @(negedge clk); en = 0;
        @(negedge clk);
        chk("lat_n2", FS'(valid), '0);
        @(negedge clk);
        chk("lat_n3", FS'(valid), FS'(1));
        chk("normal_lit", data, LIT_N);
        chk("model_normal", exp_q.size() > 0 ? exp_q[0] : '0, LIT_N);
        @(negedge clk);
        chk("hold_stable", data, LIT_N);
        do_reset();

        // debug frame, mode flips right after capture
        lser = '0; ch = '0; full = '0; sel = 8'h3C; fsm = 3'd5; ro = 16'h00FF; mode = 1; en = 1;
        @(negedge clk); en = 0; mode = 0;
        repeat (2) @(negedge clk);
        chk("debug_lit", data, LIT_D);
        chk("model_debug", exp_q.size() > 0 ? exp_q[0] : '0, LIT_D);
        do_reset();

        // backpressure: 6 frames into depth 4
        for (int i = 0; i < 6; i++) begin lser = 32'(i); en = 1; @(negedge clk); end
        en = 0;
        repeat (4) @(negedge clk);
        chk("bp_level", FS'(level), FS'(4));
        chk("bp_drop", FS'(drop), FS'(2));
        rdy = 1;
        pop_expect(8'h00, "bp0"); pop_expect(8'h01, "bp1");
        pop_expect(8'h02, "bp2"); pop_expect(8'h03, "bp3");
        en = 1; @(negedge clk); @(negedge clk); en = 0;
        pop_expect(8'h84, "bp_loss"); pop_expect(8'h05, "bp_noloss");
        do_reset();

        // push and pop together while full
        for (int c = 1; c <= 9; c++) begin
            lser = 32'(c); en = c <= 5; rdy = c == 7;
            @(negedge clk);
        end
        chk("pp_level", FS'(level), FS'(4));
        chk("pp_drop", FS'(drop), '0);
        rdy = 1;
        pop_expect(8'h01, "pp1"); pop_expect(8'h02, "pp2");
        pop_expect(8'h03, "pp3"); pop_expect(8'h04, "pp4");
        do_reset();

        // clear stats after 10 frames with drops and a pending loss flag
        en = 1; repeat (10) @(negedge clk); en = 0;
        repeat (4) @(negedge clk);
        chk("clr_pre_drop", FS'(drop), FS'(6));
        rdy = 1; repeat (6) @(negedge clk);
        clr = 1; @(negedge clk); clr = 0;
        chk("clr_drop", FS'(drop), '0);
        en = 1; @(negedge clk); en = 0;
        pop_expect(8'h00, "clr_seq");
        do_reset();

        // async reset mid-burst
        en = 1; repeat (8) @(negedge clk);
        chk("burst_drop", FS'(drop), FS'(2));
        #2 rst = 1;
        #1;
        chk("arst_valid", FS'(valid), '0);
        chk("arst_level", FS'(level), '0);
        chk("arst_drop", FS'(drop), '0);
        en = 0;
        @(negedge clk); rst = 0; @(negedge clk);

        // sequence wrap at 64
        rdy = 1; en = 1; repeat (64) @(negedge clk); en = 0;
        repeat (5) @(negedge clk);
        en = 1; @(negedge clk); en = 0;
        pop_expect(8'h00, "wrap");
        do_reset();

        // drop counter saturation
        en = 1; repeat (65545) @(negedge clk); en = 0;
        repeat (4) @(negedge clk);
        chk("sat_drop", FS'(drop), FS'(16'hFFFF));
        chk("sat_level", FS'(level), FS'(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
